// File: rtl/cv32e40p_trace_buffer.sv
// Retirement trace buffer: records {instr, pc} of retiring instructions in a ring,
// stops a programmable number of entries after a trigger, then drains oldest-first.
module cv32e40p_trace_buffer #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned POST_TRIG    = 4,
    parameter int unsigned STOP_ON_FULL = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     valid_i,
    input  logic [31:0]              pc_i,
    input  logic [31:0]              instr_i,
    input  logic                     trigger_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [31:0]              rd_pc_o,
    output logic [31:0]              rd_instr_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [1:0]               state_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] POST_C  = CW'(POST_TRIG);

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        POST   = 2'd1,
        FROZEN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   post_q, post_d;
    logic            overflow_q, overflow_d;
    logic [63:0]     mem [DEPTH];

    logic            frozen;
    logic            capture;
    logic            pop;
    logic [AW-1:0]   rd_idx;

    // Encoding 3 is unreachable; the MSB alone selects frozen behaviour so it acts as FROZEN.
    assign frozen  = state_q[1];
    assign capture = valid_i && !frozen && !clear_i;
    assign pop     = rd_valid_o && rd_ready_i;
    assign rd_idx  = wr_ptr_q - count_q[AW-1:0];

    // NOTE: every variable gets its default before any branch so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        post_d     = post_q;
        overflow_d = overflow_q;

        if (clear_i) begin
            state_d    = ARMED;
            wr_ptr_d   = '0;
            count_d    = '0;
            post_d     = '0;
            overflow_d = 1'b0;
        end else begin
            if (capture) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q != DEPTH_C) begin
                    count_d = count_q + 1'b1;
                end else if (STOP_ON_FULL == 0) begin
                    overflow_d = 1'b1;
                end
            end

            case (state_q)
                ARMED: begin
                    if (trigger_i) begin
                        post_d  = POST_C;
                        state_d = (POST_TRIG == 0) ? FROZEN : POST;
                    end
                end
                POST: begin
                    if (capture) begin
                        post_d = post_q - 1'b1;
                        if (post_q == CW'(1)) begin
                            state_d = FROZEN;
                        end
                    end
                end
                default: begin
                    if (pop) begin
                        count_d = count_q - 1'b1;
                    end
                end
            endcase

            // Freeze-when-full: the capture that fills the last slot stops recording.
            if ((STOP_ON_FULL != 0) && capture && (count_q == DEPTH_C - 1'b1)) begin
                state_d = FROZEN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARMED;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            post_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            post_q     <= post_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: trace storage is deliberately not reset; count_q alone decides which slots are valid.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            mem[wr_ptr_q] <= {instr_i, pc_i};
        end
    end

    assign rd_valid_o = frozen && (count_q != '0);
    assign rd_pc_o    = mem[rd_idx][31:0];
    assign rd_instr_o = mem[rd_idx][63:32];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// Bench: circular and stop-on-full buffers side by side, checked every cycle against a queue model.
module tb_cv32e40p_trace_buffer;

    localparam int DEPTH     = 4;
    localparam int POST_TRIG = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] instr_i = '0;
    logic        trigger_i = 1'b0;
    logic        rd_ready_i = 1'b0;

    logic        rd_valid [2];
    logic [31:0] rd_pc    [2];
    logic [31:0] rd_instr [2];
    logic [2:0]  count    [2];
    logic        overflow [2];
    logic [1:0]  state    [2];

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    cv32e40p_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .STOP_ON_FULL(0)) dut_circ (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
        .pc_i(pc_i), .instr_i(instr_i), .trigger_i(trigger_i),
        .rd_valid_o(rd_valid[0]), .rd_ready_i(rd_ready_i), .rd_pc_o(rd_pc[0]),
        .rd_instr_o(rd_instr[0]), .count_o(count[0]), .overflow_o(overflow[0]),
        .state_o(state[0])
    );

    cv32e40p_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .STOP_ON_FULL(1)) dut_stop (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .valid_i(valid_i),
        .pc_i(pc_i), .instr_i(instr_i), .trigger_i(trigger_i),
        .rd_valid_o(rd_valid[1]), .rd_ready_i(rd_ready_i), .rd_pc_o(rd_pc[1]),
        .rd_instr_o(rd_instr[1]), .count_o(count[1]), .overflow_o(overflow[1]),
        .state_o(state[1])
    );

    // Reference model: the buffer is a queue of recorded entries, oldest at the front.
    typedef logic [63:0] entry_q_t[$];
    entry_q_t mq [2];
    int       mst  [2] = '{0, 0};
    int       mpost[2] = '{0, 0};
    bit       mov  [2] = '{0, 0};

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int m = 0; m < 2; m++) begin
                mq[m].delete();
                mst[m] = 0; mpost[m] = 0; mov[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (clear_i) begin
                    mq[m].delete();
                    mst[m] = 0; mpost[m] = 0; mov[m] = 0;
                end else if (mst[m] != 2) begin
                    int old_st;
                    old_st = mst[m];
                    if (valid_i) begin
                        mq[m].push_back({instr_i, pc_i});
                        if (mq[m].size() > DEPTH) begin
                            void'(mq[m].pop_front());
                            mov[m] = 1;
                        end
                    end
                    if (old_st == 0 && trigger_i) begin
                        mpost[m] = POST_TRIG;
                        mst[m]   = (POST_TRIG == 0) ? 2 : 1;
                    end else if (old_st == 1 && valid_i) begin
                        mpost[m]--;
                        if (mpost[m] == 0) mst[m] = 2;
                    end
                    if (m == 1 && valid_i && mq[m].size() == DEPTH) mst[m] = 2;
                end else if (mq[m].size() != 0 && rd_ready_i) begin
                    void'(mq[m].pop_front());
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        for (int m = 0; m < 2; m++) begin
            bit exp_valid;
            exp_valid = (mst[m] == 2) && (mq[m].size() != 0);
            check($sformatf("model_state[%0d]", m), 64'(state[m]), 64'(mst[m]));
            check($sformatf("model_count[%0d]", m), 64'(count[m]), 64'(mq[m].size()));
            check($sformatf("model_overflow[%0d]", m), 64'(overflow[m]), 64'(mov[m]));
            check($sformatf("model_rd_valid[%0d]", m), 64'(rd_valid[m]), 64'(exp_valid));
            if (exp_valid) begin
                check($sformatf("model_rd_pc[%0d]", m), 64'(rd_pc[m]), 64'(mq[m][0][31:0]));
                check($sformatf("model_rd_instr[%0d]", m), 64'(rd_instr[m]), 64'(mq[m][0][63:32]));
            end
        end
    end

    // Drive one cycle's inputs, then return at the following falling edge.
    task automatic cyc(input bit v, input logic [31:0] pc, input bit trig, input bit rdy, input bit clr);
        valid_i    = v;
        pc_i       = pc;
        instr_i    = pc ^ 32'hA5A5_0000;
        trigger_i  = trig;
        rd_ready_i = rdy;
        clear_i    = clr;
        @(negedge clk_i);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain(input int m, input logic [31:0] first_pc, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("drain_valid[%0d] #%0d", m, i), 64'(rd_valid[m]), 64'(1));
            check($sformatf("drain_pc[%0d] #%0d", m, i), 64'(rd_pc[m]), 64'(first_pc + 32'(4 * i)));
            cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
        check($sformatf("drain_done[%0d]", m), 64'(rd_valid[m]), 64'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        check("reset_state", 64'(state[0]), 64'(0));
        check("reset_count", 64'(count[0]), 64'(0));
        check("reset_rd_valid", 64'(rd_valid[0]), 64'(0));
        rst_ni = 1'b1;
        idle();

        // Six captures, trigger on the third: the oldest entry is overwritten.
        for (int i = 0; i < 6; i++) cyc(1'b1, 32'h100 + 32'(4 * i), i == 2, 1'b0, 1'b0);
        check("seq1_state", 64'(state[0]), 64'(2));
        check("seq1_count", 64'(count[0]), 64'(4));
        check("seq1_overflow", 64'(overflow[0]), 64'(1));
        drain(0, 32'h104, 4);

        // Trigger coincident with a capture: trigger entry comes out first.
        clear();
        cyc(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
        check("seq2_still_post", 64'(state[0]), 64'(1));
        cyc(1'b1, 32'h208, 1'b0, 1'b0, 1'b0);
        check("seq2_state", 64'(state[0]), 64'(2));
        drain(0, 32'h200, 3);

        // Stop-on-full: freezes on the fourth capture and ignores the fifth.
        clear();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
            if (i == 3) check("seq3_frozen_at_4", 64'(state[1]), 64'(2));
        end
        check("seq3_count", 64'(count[1]), 64'(4));
        check("seq3_overflow", 64'(overflow[1]), 64'(0));
        check("seq3_circ_overflow", 64'(overflow[0]), 64'(1));
        drain(1, 32'h300, 4);

        // Clear wins over a same-cycle readout handshake.
        clear();
        cyc(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h208, 1'b0, 1'b0, 1'b0);
        check("seq4_count3", 64'(count[0]), 64'(3));
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("seq4_state", 64'(state[0]), 64'(0));
        check("seq4_count", 64'(count[0]), 64'(0));
        check("seq4_rd_valid", 64'(rd_valid[0]), 64'(0));

        // Asynchronous reset in the middle of POST, observed before any clock edge.
        cyc(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
        check("seq5_in_post", 64'(state[0]), 64'(1));
        #2 rst_ni = 1'b0;
        #1;
        check("seq5_async_state", 64'(state[0]), 64'(0));
        check("seq5_async_count", 64'(count[0]), 64'(0));
        check("seq5_async_rd_valid", 64'(rd_valid[0]), 64'(0));
        check("seq5_async_overflow", 64'(overflow[0]), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h508, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("seq5_hold_valid", 64'(rd_valid[0]), 64'(1));
            check("seq5_hold_pc", 64'(rd_pc[0]), 64'(32'h500));
            idle();
        end

        // Randomized traffic, judged by the per-cycle model comparison.
        clear();
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 8,
                $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40p_trace_buffer.md
CV32E40P_TRACE_BUFFER -- requirements
Module: cv32e40p_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of trace entries; power of two, >= 2.
REQ-002 SHALL have parameter POST_TRIG, default 4: entries captured after a trigger; range 0..DEPTH-1.
REQ-003 SHALL have parameter STOP_ON_FULL, default 0: 0 = circular (oldest overwritten), 1 = freeze when full.
REQ-004 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port clear_i, input, 1: flush buffer and re-arm.
REQ-007 SHALL have port valid_i, input, 1: an instruction retires this cycle.
REQ-008 SHALL have port pc_i, input, 32: PC of the retiring instruction.
REQ-009 SHALL have port instr_i, input, 32: encoding of the retiring instruction.
REQ-010 SHALL have port trigger_i, input, 1: trigger event.
REQ-011 SHALL have port rd_valid_o, output, 1: a readout entry is available.
REQ-012 SHALL have port rd_ready_i, input, 1: consumer accepts the readout entry.
REQ-013 SHALL have port rd_pc_o, output, 32: PC of the readout entry.
REQ-014 SHALL have port rd_instr_o, output, 32: instruction of the readout entry.
REQ-015 SHALL have port count_o, output, $clog2(DEPTH)+1: number of valid entries.
REQ-016 SHALL have port overflow_o, output, 1: sticky flag, an entry was overwritten.
REQ-017 SHALL have port state_o, output, 2: FSM state (ARMED=0, POST=1, FROZEN=2).

Function
REQ-018 SHALL implement FSM states ARMED, POST and FROZEN; 3 is unreachable and SHALL be treated as FROZEN.
REQ-019 In ARMED/POST, valid_i=1 SHALL write {instr_i,pc_i} at wr_ptr on that clock edge; wr_ptr increments modulo DEPTH.
REQ-020 On capture with count_o<DEPTH, count_o SHALL increment; with count_o==DEPTH it SHALL stay DEPTH and overflow_o SHALL set (circular mode only).
REQ-021 If STOP_ON_FULL=1, the capture that makes count_o==DEPTH SHALL move ARMED->FROZEN; overflow_o never sets in this mode.
REQ-022 In ARMED, trigger_i=1 SHALL move the FSM to POST with post counter=POST_TRIG, or to FROZEN if POST_TRIG==0; a same-cycle valid_i entry is captured (the trigger entry).
REQ-023 In POST, each capture SHALL decrement the post counter; the capture that takes it from 1 to 0 SHALL move POST->FROZEN.
REQ-024 trigger_i SHALL be ignored in POST and FROZEN; valid_i SHALL be ignored in FROZEN.
REQ-025 In FROZEN: rd_valid_o = (count_o!=0); rd_pc_o/rd_instr_o SHALL present the entry at (wr_ptr-count_o) mod DEPTH, oldest first.
REQ-026 rd_valid_o SHALL be 0 outside FROZEN; rd_ready_i SHALL be ignored there.
REQ-027 rd_valid_o&&rd_ready_i SHALL decrement count_o by 1 on that edge; the next-oldest entry is presented the following cycle; rd_valid_o SHALL not drop without a handshake.
REQ-028 FROZEN with count_o==0 SHALL remain FROZEN until clear_i.
REQ-029 clear_i=1 SHALL, from any state, set ARMED, wr_ptr=0, count_o=0, overflow_o=0, post counter=0 on the next edge, and SHALL override the same-cycle valid_i, trigger_i and readout handshake.
REQ-030 rd_pc_o/rd_instr_o SHALL be don't-care when rd_valid_o=0; storage need not be reset.
REQ-031 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from valid_i, pc_i or instr_i to any output.

Reset
REQ-032 rst_ni=0 SHALL asynchronously force ARMED, wr_ptr=0, count_o=0, overflow_o=0, rd_valid_o=0, state_o=0 and post counter=0, including mid-POST or mid-readout.
REQ-033 After rst_ni deasserts, the first capture SHALL occur on the first rising edge with valid_i=1.

Verification (DEPTH=4, POST_TRIG=2, STOP_ON_FULL=0 unless stated)
REQ-034 Sequence: 6 captures with PC 0x100..0x114 step 4, trigger on the 3rd, then readout -> FROZEN after the 5th capture; count_o=4; overflow_o=1; readout PCs 0x104,0x108,0x10C,0x110; rd_valid_o=0 afterwards.
REQ-035 Sequence: trigger_i and valid_i in the same cycle with PC=0x200, then 2 more captures -> trigger entry 0x200 is read out before the two post entries; state_o=2.
REQ-036 Sequence: STOP_ON_FULL=1, 5 captures without trigger -> FROZEN after the 4th; 5th ignored; overflow_o=0; readout 4 entries.
REQ-037 Sequence: in FROZEN with count_o=3, clear_i asserted together with rd_valid&&rd_ready -> next cycle ARMED, count_o=0, rd_valid_o=0.
REQ-038 Sequence: rst_ni asserted mid-POST, then readout hold with rd_ready_i=0 -> outputs reset immediately without a clock edge; rd_pc_o stays stable while rd_ready_i=0 in FROZEN.
